alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width; only 8 is supported by the byte protocol.
REQ-002 SHALL have parameter RX_TIMEOUT, default 255: maximum idle cycles allowed between frame bytes.
REQ-003 SHALL have parameter RES_TIMEOUT, default 4: maximum cycles after ALU_EN before ALU_OUT_VALID must arrive.

Ports
REQ-004 SHALL have port ALU_CLK, input, 1 bit: clock.
REQ-005 SHALL have port RST_SYNC_2, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port RX_DATA, input, 8 bits: incoming command byte.
REQ-007 SHALL have port RX_VALID, input, 1 bit: RX_DATA valid.
REQ-008 SHALL have port RX_READY, output, 1 bit: sequencer accepts a byte.
REQ-009 SHALL have port REG0, output, DATA_WIDTH bits: ALU operand A.
REQ-010 SHALL have port REG1, output, DATA_WIDTH bits: ALU operand B.
REQ-011 SHALL have port ALU_FUNC, output, 4 bits: ALU opcode.
REQ-012 SHALL have port ALU_EN, output, 1 bit: ALU execute strobe.
REQ-013 SHALL have port ALU_OUT, input, 16 bits: registered ALU result.
REQ-014 SHALL have port ALU_OUT_VALID, input, 1 bit: ALU_OUT valid.
REQ-015 SHALL have port TX_DATA, output, 8 bits: result byte.
REQ-016 SHALL have port TX_VALID, output, 1 bit: TX_DATA valid.
REQ-017 SHALL have port TX_READY, input, 1 bit: downstream accepts a byte.
REQ-018 SHALL have port FRAME_ERR, output, 1 bit: one-cycle error pulse.
REQ-019 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-020 A byte SHALL transfer on RX when RX_VALID and RX_READY are both high at a rising ALU_CLK edge; the same rule applies on TX with TX_VALID and TX_READY.
REQ-021 Frame SHALL be: header {4'hA, FUNC}, then operand A, then operand B; FUNC 4'hD and 4'hE SHALL take operand A only, with REG1 driven to 0.
REQ-022 FSM states SHALL be IDLE, GET_A, GET_B, EXEC, WAIT_RES, SEND_LO, SEND_HI.
REQ-023 IDLE: on a header with upper nibble 4'hA, SHALL latch FUNC into ALU_FUNC and go to GET_A; any other upper nibble SHALL pulse FRAME_ERR and stay in IDLE.
REQ-024 GET_A SHALL latch REG0 and go to GET_B, or to EXEC for a shift opcode; GET_B SHALL latch REG1 and go to EXEC.
REQ-025 RX_READY SHALL be high only in IDLE, GET_A and GET_B.
REQ-026 In GET_A or GET_B, RX_TIMEOUT consecutive cycles without a transfer SHALL pulse FRAME_ERR and return to IDLE; the counter SHALL clear on every transfer.
REQ-027 EXEC SHALL assert ALU_EN for exactly one cycle, then go to WAIT_RES; REG0, REG1 and ALU_FUNC SHALL stay stable until the next header.
REQ-028 WAIT_RES SHALL capture ALU_OUT into a 16-bit result register on the first cycle ALU_OUT_VALID is high, then go to SEND_LO; nominal EXEC-to-capture latency is 2 cycles.
REQ-029 If ALU_OUT_VALID does not arrive within RES_TIMEOUT cycles of entering WAIT_RES, the block SHALL pulse FRAME_ERR and return to IDLE with no TX.
REQ-030 SEND_LO SHALL present result[7:0], SEND_HI SHALL present result[15:8]; TX_VALID SHALL be high in both states, and TX_DATA SHALL hold stable until the transfer.
REQ-031 A transfer in SEND_HI SHALL return the FSM to IDLE; a new header SHALL be accepted the following cycle.
REQ-032 ALU_OUT_VALID outside WAIT_RES SHALL be ignored.

Reset
REQ-033 Asserting RST_SYNC_2 low SHALL immediately force state to IDLE and clear REG0, REG1, ALU_FUNC, ALU_EN, TX_DATA, TX_VALID, FRAME_ERR, BUSY, the result register and both counters.
REQ-034 After reset release, RX_READY SHALL be 1 because the state is IDLE.
REQ-035 Reset mid-frame or mid-send SHALL drop the frame, and no remaining byte SHALL be emitted after release.

Structure
REQ-036 Package alu_cmd_pkg SHALL hold the state encoding, the header marker 4'hA, the shift opcodes 4'hD/4'hE and the default timeout constants.
REQ-037 Sub-module alu_cmd_tmr SHALL be a loadable down-counter with an expiry flag, shared by the RX timeout and the result timeout.

Verification
REQ-038 Bytes 0xA0, 0x12, 0x34 with a model ALU -> one ALU_EN pulse with REG0=0x12, REG1=0x34, ALU_FUNC=0 -> TX 0x46 then 0x00.
REQ-039 Bytes 0xA2, 0xFF, 0xFF with TX_READY low for 3 cycles -> TX_DATA holds 0x01 -> then TX 0x01, 0xFE.
REQ-040 Bytes 0xAD, 0x81 -> only 2 bytes consumed, REG1=0 -> TX 0x40, 0x00.
REQ-041 Header 0x35 -> FRAME_ERR pulses once, BUSY stays 0; a 256-cycle gap after 0xA0 -> FRAME_ERR, return to IDLE.
REQ-042 Model ALU never asserting ALU_OUT_VALID -> FRAME_ERR 4 cycles after WAIT_RES is entered, no TX.
REQ-043 Reset asserted during SEND_HI -> TX_VALID drops immediately; after release, the next frame processes correctly.

Source files
------------

// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encoding,
// frame header marker, shift opcodes and default timeout values.
package alu_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_A    = 3'd1,
      GET_B    = 3'd2,
      EXEC     = 3'd3,
      WAIT_RES = 3'd4,
      SEND_LO  = 3'd5,
      SEND_HI  = 3'd6
   } state_t;

   localparam logic [3:0] HDR_MARK = 4'hA;
   localparam logic [3:0] OP_SHR   = 4'hD;
   localparam logic [3:0] OP_SHL   = 4'hE;

   localparam int RX_TIMEOUT_DEF  = 255;
   localparam int RES_TIMEOUT_DEF = 4;

   // Shift opcodes carry a single operand, so the frame skips operand B.
   function automatic logic is_shift(input logic [3:0] func);
      return (func == OP_SHR) || (func == OP_SHL);
   endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Bundle of the byte-stream, ALU and status signals around the sequencer.
// slave is the sequencer's view, master is the surrounding system's view.
interface alu_cmd_seq_if #(
   parameter int DATA_WIDTH = 8
);
   logic [7:0]            RX_DATA;
   logic                  RX_VALID;
   logic                  RX_READY;
   logic [DATA_WIDTH-1:0] REG0;
   logic [DATA_WIDTH-1:0] REG1;
   logic [3:0]            ALU_FUNC;
   logic                  ALU_EN;
   logic [15:0]           ALU_OUT;
   logic                  ALU_OUT_VALID;
   logic [7:0]            TX_DATA;
   logic                  TX_VALID;
   logic                  TX_READY;
   logic                  FRAME_ERR;
   logic                  BUSY;

   modport slave (
      input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
      output RX_READY, REG0, REG1, ALU_FUNC, ALU_EN, TX_DATA, TX_VALID,
             FRAME_ERR, BUSY
   );

   modport master (
      output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
      input  RX_READY, REG0, REG1, ALU_FUNC, ALU_EN, TX_DATA, TX_VALID,
             FRAME_ERR, BUSY
   );
endinterface

// File: rtl/alu_cmd_seq_tmr.sv
// Loadable down-counter with an expiry flag. The flag is raised during the
// last permitted waiting cycle, so the owner can abort on that clock edge.
module alu_cmd_tmr #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load takes priority; otherwise count down while enabled, saturating at 0.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with asynchronous active-low clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && !load_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: parses {A,FUNC}/A/B byte frames, strobes the ALU,
// waits for its 16-bit result and returns it low byte first.
module alu_cmd_seq
   import alu_cmd_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int RX_TIMEOUT  = RX_TIMEOUT_DEF,
   parameter int RES_TIMEOUT = RES_TIMEOUT_DEF
) (
   input  logic          ALU_CLK,
   input  logic          RST_SYNC_2,
   alu_cmd_seq_if.slave  bus
);

   localparam int TMR_MAX = (RX_TIMEOUT > RES_TIMEOUT) ? RX_TIMEOUT : RES_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] reg0_q;
   logic [DATA_WIDTH-1:0] reg1_q;
   logic [3:0]            func_q;
   logic [15:0]           result_q;
   logic                  frame_err_q;
   logic                  frame_err_d;

   logic                  rx_ready;
   logic                  tx_valid;
   logic                  rx_xfer;
   logic                  tx_xfer;
   logic                  hdr_ok;

   logic                  tmr_load;
   logic                  tmr_en;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_exp;

   assign rx_xfer = bus.RX_VALID && rx_ready;
   assign tx_xfer = tx_valid && bus.TX_READY;
   assign hdr_ok  = (bus.RX_DATA[7:4] == HDR_MARK);

   // One timer serves both waits: it runs in the operand states and in
   // WAIT_RES, and is reloaded everywhere else and on every received byte.
   // Leaving EXEC loads the result budget; all other reloads use the RX budget.
   assign tmr_en   = (state_q == GET_A) || (state_q == GET_B) || (state_q == WAIT_RES);
   assign tmr_load = !tmr_en || rx_xfer;
   assign tmr_val  = (state_q == EXEC) ? TMR_W'(RES_TIMEOUT) : TMR_W'(RX_TIMEOUT);

   alu_cmd_tmr #(
      .CNT_W      (TMR_W)
   ) u_tmr (
      .clk_i      (ALU_CLK),
      .rst_n_i    (RST_SYNC_2),
      .load_i     (tmr_load),
      .en_i       (tmr_en),
      .load_val_i (tmr_val),
      .expired_o  (tmr_exp)
   );

   // State register; reset drops any frame in progress.
   always_ff @(posedge ALU_CLK or negedge RST_SYNC_2) begin
      if (!RST_SYNC_2) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and error-pulse decision; a byte arriving wins over a timeout.
   always_comb begin
      state_d     = state_q;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_xfer) begin
               if (hdr_ok) begin
                  state_d = GET_A;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         GET_A: begin
            if (rx_xfer) begin
               state_d = is_shift(func_q) ? EXEC : GET_B;
            end else if (tmr_exp) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end
         end
         GET_B: begin
            if (rx_xfer) begin
               state_d = EXEC;
            end else if (tmr_exp) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end
         end
         EXEC: begin
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (bus.ALU_OUT_VALID) begin
               state_d = SEND_LO;
            end else if (tmr_exp) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end
         end
         SEND_LO: begin
            if (tx_xfer) begin
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            if (tx_xfer) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand, opcode and result capture; values hold until the next header.
   always_ff @(posedge ALU_CLK or negedge RST_SYNC_2) begin
      if (!RST_SYNC_2) begin
         reg0_q      <= '0;
         reg1_q      <= '0;
         func_q      <= '0;
         result_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         if ((state_q == IDLE) && rx_xfer && hdr_ok) begin
            func_q <= bus.RX_DATA[3:0];
         end
         if ((state_q == GET_A) && rx_xfer) begin
            reg0_q <= DATA_WIDTH'(bus.RX_DATA);
            if (is_shift(func_q)) begin
               reg1_q <= '0;
            end
         end
         if ((state_q == GET_B) && rx_xfer) begin
            reg1_q <= DATA_WIDTH'(bus.RX_DATA);
         end
         if ((state_q == WAIT_RES) && bus.ALU_OUT_VALID) begin
            result_q <= bus.ALU_OUT;
         end
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      rx_ready    = 1'b0;
      tx_valid    = 1'b0;
      bus.ALU_EN  = 1'b0;
      bus.TX_DATA = 8'h00;
      case (state_q)
         IDLE, GET_A, GET_B: rx_ready = 1'b1;
         EXEC:               bus.ALU_EN = 1'b1;
         SEND_LO: begin
            tx_valid    = 1'b1;
            bus.TX_DATA = result_q[7:0];
         end
         SEND_HI: begin
            tx_valid    = 1'b1;
            bus.TX_DATA = result_q[15:8];
         end
         default: begin
            rx_ready = 1'b0;
         end
      endcase
   end

   assign bus.RX_READY  = rx_ready;
   assign bus.TX_VALID  = tx_valid;
   assign bus.REG0      = reg0_q;
   assign bus.REG1      = reg1_q;
   assign bus.ALU_FUNC  = func_q;
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for the ALU command sequencer: byte frames in, model ALU alongside,
// expected TX bytes queued at stimulus time and matched as they leave.
module tb_alu_cmd_seq;

   logic ALU_CLK    = 1'b0;
   logic RST_SYNC_2 = 1'b0;
   logic alu_dead   = 1'b0;

   int total    = 0;
   int bad      = 0;
   int err_cnt  = 0;
   int en_cnt   = 0;
   int busy_cnt = 0;
   int extra_tx = 0;

   logic [7:0] exp_q[$];

   alu_cmd_seq_if #(.DATA_WIDTH(8)) bus ();

   alu_cmd_seq #(
      .DATA_WIDTH  (8),
      .RX_TIMEOUT  (255),
      .RES_TIMEOUT (4)
   ) dut (
      .ALU_CLK    (ALU_CLK),
      .RST_SYNC_2 (RST_SYNC_2),
      .bus        (bus)
   );

   always #5 ALU_CLK = ~ALU_CLK;

   function automatic logic [15:0] alu_ref(input logic [3:0] f,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
      logic [15:0] wa;
      logic [15:0] wb;
      wa = {8'h00, a};
      wb = {8'h00, b};
      case (f)
         4'h0:    return wa + wb;
         4'h1:    return wa - wb;
         4'h2:    return wa * wb;
         4'h3:    return wa & wb;
         4'hD:    return wa >> 1;
         4'hE:    return wa << 1;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model ALU: one register stage, result valid the cycle after ALU_EN.
   always @(posedge ALU_CLK or negedge RST_SYNC_2) begin
      if (!RST_SYNC_2) begin
         bus.ALU_OUT       <= 16'h0000;
         bus.ALU_OUT_VALID <= 1'b0;
      end else begin
         bus.ALU_OUT_VALID <= bus.ALU_EN && !alu_dead;
         if (bus.ALU_EN) begin
            bus.ALU_OUT <= alu_ref(bus.ALU_FUNC, bus.REG0, bus.REG1);
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge ALU_CLK) begin
      if (RST_SYNC_2) begin
         if (bus.FRAME_ERR) err_cnt++;
         if (bus.ALU_EN)    en_cnt++;
         if (bus.BUSY)      busy_cnt++;
         if (bus.TX_VALID && bus.TX_READY) begin
            if (exp_q.size() == 0) begin
               extra_tx++;
            end else begin
               chk("tx_byte", bus.TX_DATA, exp_q.pop_front());
            end
         end
      end
   end

   task automatic push_res(input logic [15:0] r);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.RX_DATA  = b;
      bus.RX_VALID = 1'b1;
      @(negedge ALU_CLK);
      while (!bus.RX_READY && n < 50) begin
         @(negedge ALU_CLK);
         n++;
      end
      chk("rx_accept", bus.RX_READY, 1);
      @(posedge ALU_CLK);
      #1;
      bus.RX_VALID = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge ALU_CLK);
      while ((exp_q.size() != 0 || bus.BUSY) && n < 200) begin
         @(negedge ALU_CLK);
         n++;
      end
      chk(tag, bus.BUSY, 0);
      @(posedge ALU_CLK);
      #1;
   endtask

   task automatic wait_tx_valid(input string tag);
      int n = 0;
      @(negedge ALU_CLK);
      while (!bus.TX_VALID && n < 30) begin
         @(negedge ALU_CLK);
         n++;
      end
      chk(tag, bus.TX_VALID, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int e0;
      int b0;
      bus.RX_DATA  = 8'h00;
      bus.RX_VALID = 1'b0;
      bus.TX_READY = 1'b1;

      // reset state
      repeat (3) @(negedge ALU_CLK);
      chk("rst_rx_ready",  bus.RX_READY,  1);
      chk("rst_busy",      bus.BUSY,      0);
      chk("rst_tx_valid",  bus.TX_VALID,  0);
      chk("rst_alu_en",    bus.ALU_EN,    0);
      chk("rst_frame_err", bus.FRAME_ERR, 0);
      chk("rst_reg0",      bus.REG0,      0);
      chk("rst_reg1",      bus.REG1,      0);
      chk("rst_func",      bus.ALU_FUNC,  0);
      chk("rst_tx_data",   bus.TX_DATA,   0);
      @(posedge ALU_CLK); #1;
      RST_SYNC_2 = 1'b1;
      @(negedge ALU_CLK);
      chk("rel_rx_ready", bus.RX_READY, 1);
      @(posedge ALU_CLK); #1;

      // add frame
      e0 = en_cnt;
      push_res(alu_ref(4'h0, 8'h12, 8'h34));
      send_byte(8'hA0); send_byte(8'h12); send_byte(8'h34);
      wait_idle("t1_idle");
      chk("t1_reg0", bus.REG0, 8'h12);
      chk("t1_reg1", bus.REG1, 8'h34);
      chk("t1_func", bus.ALU_FUNC, 4'h0);
      chk("t1_en_pulses", en_cnt - e0, 1);

      // multiply with TX back-pressure
      bus.TX_READY = 1'b0;
      push_res(16'hFE01);
      send_byte(8'hA2); send_byte(8'hFF); send_byte(8'hFF);
      wait_tx_valid("t2_tx_valid");
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold", bus.TX_DATA, 8'h01);
         @(negedge ALU_CLK);
      end
      @(posedge ALU_CLK); #1;
      bus.TX_READY = 1'b1;
      wait_idle("t2_idle");

      // shift right: two bytes only, REG1 forced to zero
      push_res(16'h0040);
      send_byte(8'hAD); send_byte(8'h81);
      @(negedge ALU_CLK);
      chk("t3_rx_ready", bus.RX_READY, 0);
      chk("t3_alu_en",   bus.ALU_EN,   1);
      chk("t3_reg0",     bus.REG0,     8'h81);
      chk("t3_reg1",     bus.REG1,     8'h00);
      chk("t3_func",     bus.ALU_FUNC, 4'hD);
      wait_idle("t3_idle");

      // shift left
      push_res(16'h0102);
      send_byte(8'hAE); send_byte(8'h81);
      wait_idle("t3b_idle");

      // bad header
      e0 = err_cnt;
      b0 = busy_cnt;
      send_byte(8'h35);
      repeat (3) @(negedge ALU_CLK);
      chk("t4_hdr_err", err_cnt - e0, 1);
      chk("t4_hdr_busy", busy_cnt - b0, 0);
      @(posedge ALU_CLK); #1;

      // RX gap timeout after header
      send_byte(8'hA0);
      repeat (255) @(negedge ALU_CLK);
      chk("t4_gap_early_err", bus.FRAME_ERR, 0);
      chk("t4_gap_busy", bus.BUSY, 1);
      @(negedge ALU_CLK);
      chk("t4_gap_err", bus.FRAME_ERR, 1);
      chk("t4_gap_idle", bus.BUSY, 0);
      @(negedge ALU_CLK);
      chk("t4_gap_pulse", bus.FRAME_ERR, 0);
      @(posedge ALU_CLK); #1;

      // ALU never answers
      alu_dead = 1'b1;
      e0 = en_cnt;
      send_byte(8'hA0); send_byte(8'h01); send_byte(8'h02);
      repeat (5) @(negedge ALU_CLK);
      chk("t5_early_err", bus.FRAME_ERR, 0);
      chk("t5_busy", bus.BUSY, 1);
      @(negedge ALU_CLK);
      chk("t5_res_err", bus.FRAME_ERR, 1);
      chk("t5_idle", bus.BUSY, 0);
      repeat (4) @(negedge ALU_CLK);
      chk("t5_en_pulses", en_cnt - e0, 1);
      alu_dead = 1'b0;
      @(posedge ALU_CLK); #1;

      // reset during SEND_HI
      bus.TX_READY = 1'b0;
      exp_q.push_back(8'h30);
      send_byte(8'hA0); send_byte(8'h10); send_byte(8'h20);
      wait_tx_valid("t6_tx_valid");
      chk("t6_lo", bus.TX_DATA, 8'h30);
      @(posedge ALU_CLK); #1;
      bus.TX_READY = 1'b1;
      @(posedge ALU_CLK); #1;
      bus.TX_READY = 1'b0;
      @(negedge ALU_CLK);
      chk("t6_hi_valid", bus.TX_VALID, 1);
      chk("t6_hi_data",  bus.TX_DATA,  8'h00);
      #2;
      RST_SYNC_2 = 1'b0;
      #1;
      chk("t6_rst_tx_valid", bus.TX_VALID, 0);
      chk("t6_rst_busy",     bus.BUSY,     0);
      chk("t6_rst_reg0",     bus.REG0,     0);
      chk("t6_rst_rx_ready", bus.RX_READY, 1);
      @(posedge ALU_CLK); #1;
      @(posedge ALU_CLK); #1;
      RST_SYNC_2   = 1'b1;
      bus.TX_READY = 1'b1;
      repeat (5) @(negedge ALU_CLK);
      chk("t6_post_busy", bus.BUSY, 0);
      @(posedge ALU_CLK); #1;
      push_res(alu_ref(4'h1, 8'h50, 8'h20));
      send_byte(8'hA1); send_byte(8'h50); send_byte(8'h20);
      wait_idle("t6_next_idle");
      chk("t6_next_reg0", bus.REG0, 8'h50);
      chk("t6_next_func", bus.ALU_FUNC, 4'h1);

      repeat (3) @(negedge ALU_CLK);
      chk("no_extra_tx", extra_tx, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
